// File: rtl/i2c_pkg.sv
// Shared definitions for the byte-level I2C master: FSM states, status bit
// positions, control-register field positions and a byte-lane selector.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_RACK,
        ST_STOP,
        ST_DONE
    } state_e;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_ANACK = 1;
    localparam int STAT_DNACK = 2;
    localparam int STAT_DONE  = 7;

    localparam int CON1_START  = 0;
    localparam int CON1_RW     = 1;
    localparam int CON1_CNT_LO = 2;

    // Quarter-period phases within one SCL bit slot
    localparam logic [1:0] PH_HALF   = 2'd1;
    localparam logic [1:0] PH_SAMPLE = 2'd2;
    localparam logic [1:0] PH_LAST   = 2'd3;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator: one tick every CLK_DIV cycles while enabled,
// with a 2-bit phase that advances on each tick.
module i2c_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       en,
    input  logic       clr,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CW = 10;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;

    assign tick  = en && (cnt_q == CW'(CLK_DIV - 1));
    assign phase = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (en) begin
            if (tick) begin
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: one START/address/1-4 data bytes/STOP transfer per
// rising edge of the start bit, with open-drain style SDA enable.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [7:0]  i2c_con1,
    input  logic [7:0]  i2c_con2,
    input  logic [31:0] Din,
    input  logic        sda_in,
    output logic [31:0] Dout,
    output logic        ready,
    output logic [7:0]  i2c_stat,
    output logic        scl_o,
    output logic        sda_oe
);

    state_e      state_q, state_d;
    logic        start_prev_q;
    logic [6:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        ack_q, ack_d;
    logic [31:0] dout_q, dout_d;
    logic        anack_q, anack_d;
    logic        dnack_q, dnack_d;
    logic        done_q, done_d;
    logic        scl_q, scl_d;
    logic        sda_oe_q, sda_oe_d;

    logic       tick;
    logic [1:0] phase;
    logic       launch, div_en, div_clr;
    logic       end_slot, sample, half;
    logic       unused_bits;

    assign unused_bits = ^{i2c_con1[7:4], i2c_con2[7]};

    assign launch   = (state_q == ST_IDLE) && i2c_con1[CON1_START] && !start_prev_q;
    assign end_slot = tick && (phase == PH_LAST);
    assign sample   = tick && (phase == PH_SAMPLE);
    assign half     = tick && (phase == PH_HALF);
    assign div_en   = (state_q != ST_IDLE);
    // START is only half a slot, so realign the phase to 0 for the first address bit
    assign div_clr  = launch || ((state_q == ST_START) && half);

    i2c_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .en     (div_en),
        .clr    (div_clr),
        .tick   (tick),
        .phase  (phase)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        ack_d   = ack_q;
        dout_d  = dout_q;
        anack_d = anack_q;
        dnack_d = dnack_q;
        done_d  = done_q;

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    addr_d  = i2c_con2[6:0];
                    rw_d    = i2c_con1[CON1_RW];
                    cnt_d   = i2c_con1[CON1_CNT_LO +: 2];
                    wdata_d = Din;
                    idx_d   = '0;
                    bit_d   = '0;
                    sh_d    = {i2c_con2[6:0], i2c_con1[CON1_RW]};
                    anack_d = 1'b0;
                    dnack_d = 1'b0;
                    done_d  = 1'b0;
                    if (i2c_con1[CON1_RW]) dout_d = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (half) state_d = ST_ADDR;
            end
            ST_ADDR, ST_WDATA: begin
                if (end_slot) begin
                    if (bit_q == 3'd7) begin
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_WACK;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {sh_q[6:0], 1'b0};
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (sample) ack_d = sda_in;
                if (end_slot) begin
                    bit_d = '0;
                    if (ack_q) begin
                        anack_d = 1'b1;
                        state_d = ST_STOP;
                    end else if (rw_q) begin
                        state_d = ST_RDATA;
                    end else begin
                        sh_d    = byte_sel(wdata_q, 2'd0);
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_WACK: begin
                if (sample) ack_d = sda_in;
                if (end_slot) begin
                    if (ack_q) begin
                        dnack_d = 1'b1;
                        state_d = ST_STOP;
                    end else if (idx_q != cnt_q) begin
                        idx_d   = idx_q + 2'd1;
                        bit_d   = '0;
                        sh_d    = byte_sel(wdata_q, idx_q + 2'd1);
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_RDATA: begin
                if (sample) sh_d = {sh_q[6:0], sda_in};
                if (end_slot) begin
                    if (bit_q == 3'd7) begin
                        for (int i = 0; i < 4; i++) begin
                            if (idx_q == 2'(i)) dout_d[8*i +: 8] = sh_q;
                        end
                        state_d = ST_RACK;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_RACK: begin
                if (end_slot) begin
                    if (idx_q == cnt_q) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        bit_d   = '0;
                        state_d = ST_RDATA;
                    end
                end
            end
            ST_STOP: begin
                if (half) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus levels are registered so SCL/SDA never glitch on decode changes
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_q)
            ST_START: sda_oe_d = 1'b1;
            ST_ADDR, ST_WDATA: begin
                scl_d    = phase[1];
                sda_oe_d = ~sh_q[7];
            end
            ST_ADDR_ACK, ST_WACK, ST_RDATA: scl_d = phase[1];
            ST_RACK: begin
                scl_d    = phase[1];
                sda_oe_d = (idx_q != cnt_q);
            end
            ST_STOP: begin
                scl_d    = phase[0];
                sda_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            cnt_q        <= '0;
            wdata_q      <= '0;
            idx_q        <= '0;
            bit_q        <= '0;
            sh_q         <= '0;
            ack_q        <= 1'b0;
            dout_q       <= '0;
            anack_q      <= 1'b0;
            dnack_q      <= 1'b0;
            done_q       <= 1'b0;
            scl_q        <= 1'b1;
            sda_oe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= i2c_con1[CON1_START];
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            cnt_q        <= cnt_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            bit_q        <= bit_d;
            sh_q         <= sh_d;
            ack_q        <= ack_d;
            dout_q       <= dout_d;
            anack_q      <= anack_d;
            dnack_q      <= dnack_d;
            done_q       <= done_d;
            scl_q        <= scl_d;
            sda_oe_q     <= sda_oe_d;
        end
    end

    always_comb begin
        i2c_stat             = '0;
        i2c_stat[STAT_BUSY]  = !ready;
        i2c_stat[STAT_ANACK] = anack_q;
        i2c_stat[STAT_DNACK] = dnack_q;
        i2c_stat[STAT_DONE]  = done_q || (state_q == ST_DONE);
    end

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign Dout   = dout_q;
    assign scl_o  = scl_q;
    assign sda_oe = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural I2C target plus bus recorder, and a
// transfer-level model of the expected bytes, ACKs, Dout and status.
module tb_i2c_master_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [7:0]  con1, con2;
    logic [31:0] Din;
    logic        sda_in;
    logic [31:0] Dout;
    logic        ready;
    logic [7:0]  stat;
    logic        scl_o, sda_oe;
    logic        tgt_sda = 1'b1;

    int tests = 0;
    int fails = 0;

    // Target configuration and bus record
    logic        cfg_anack = 1'b0;
    int          cfg_nack = -1;
    logic [31:0] cfg_rd = '0;
    logic [7:0]  rec_b[$];
    logic        rec_a[$];
    int          n_start = 0;
    int          n_stop = 0;
    int          mon_bitc = 0;
    logic [31:0] model_dout;

    always #5 PCLK = ~PCLK;

    // Wired-AND line: low if either side pulls
    assign sda_in = ~sda_oe & tgt_sda;

    i2c_master_ctrl #(.CLK_DIV(4)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .i2c_con1 (con1),
        .i2c_con2 (con2),
        .Din      (Din),
        .sda_in   (sda_in),
        .Dout     (Dout),
        .ready    (ready),
        .i2c_stat (stat),
        .scl_o    (scl_o),
        .sda_oe   (sda_oe)
    );

    initial begin
        logic       p_scl, p_sda, sda_l, rw_f, active;
        logic [7:0] shr, rbyte;
        int         bytec;
        p_scl = 1'b1; p_sda = 1'b1; rw_f = 1'b0; active = 1'b0; shr = '0; bytec = 0;
        forever begin
            @(negedge PCLK);
            sda_l = sda_in;
            if (PRESET === 1'b1) begin
                active  = 1'b0;
                tgt_sda = 1'b1;
            end else if (scl_o && p_scl && p_sda && !sda_l) begin
                n_start++; mon_bitc = 0; bytec = 0; active = 1'b1;
            end else if (scl_o && p_scl && !p_sda && sda_l) begin
                n_stop++; active = 1'b0;
            end else if (scl_o && !p_scl) begin
                if (mon_bitc < 8) begin
                    shr = {shr[6:0], sda_l};
                    mon_bitc++;
                end else begin
                    rec_b.push_back(shr);
                    rec_a.push_back(sda_l);
                    if (bytec == 0) rw_f = shr[0];
                    if (sda_l) active = 1'b0;
                    bytec++;
                    mon_bitc = 0;
                end
            end else if (!scl_o && p_scl) begin
                tgt_sda = 1'b1;
                if (active) begin
                    if (mon_bitc == 8) begin
                        if (bytec == 0) tgt_sda = cfg_anack;
                        else if (!rw_f) tgt_sda = (bytec - 1 == cfg_nack);
                    end else if (bytec > 0 && rw_f && bytec <= 4) begin
                        rbyte   = cfg_rd[8*(bytec-1) +: 8];
                        tgt_sda = rbyte[7 - mon_bitc];
                    end
                end
            end
            p_scl = scl_o;
            p_sda = sda_l;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_target(input logic an, input int nb, input logic [31:0] rd);
        cfg_anack = an;
        cfg_nack  = nb;
        cfg_rd    = rd;
        rec_b.delete();
        rec_a.delete();
        n_start = 0;
        n_stop  = 0;
    endtask

    task automatic launch(input logic [6:0] a, input logic rw, input logic [1:0] cm1,
                          input logic [31:0] din);
        con1 = 8'h00;
        @(posedge PCLK); #1;
        con1 = {4'h0, cm1, rw, 1'b1};
        con2 = {1'b0, a};
        Din  = din;
        @(posedge PCLK); #1;
        chk("launch_stat", stat, 8'h01);
        chk("launch_ready", ready, 0);
        if (rw) chk("launch_dout_clr", Dout, 0);
        // Register inputs changing mid-transfer must not matter
        con2 = 8'($urandom);
        Din  = $urandom;
        con1 = 8'($urandom) | 8'h01;
    endtask

    task automatic check_xfer(input string tag, input logic [6:0] a, input logic rw,
                              input logic [1:0] cm1, input logic [31:0] din,
                              input logic [31:0] rd, input logic an, input int nb);
        logic [8:0] exp_q[$];
        logic       dn;
        int         n, cyc;
        dn = 1'b0;
        n  = int'(cm1) + 1;
        exp_q.push_back({an, a, rw});
        if (rw) model_dout = '0;
        if (!an) begin
            for (int i = 0; i < n; i++) begin
                if (rw) begin
                    exp_q.push_back({i == n - 1, rd[8*i +: 8]});
                    model_dout[8*i +: 8] = rd[8*i +: 8];
                end else begin
                    exp_q.push_back({i == nb, din[8*i +: 8]});
                    if (i == nb) begin
                        dn = 1'b1;
                        break;
                    end
                end
            end
        end
        cyc = 0;
        while (ready !== 1'b1 && cyc < 3000) begin
            @(posedge PCLK); #1;
            cyc++;
        end
        chk({tag, "_timeout"}, ready, 1);
        repeat (3) @(posedge PCLK);
        #1;
        chk({tag, "_stat"}, stat, {1'b1, 4'b0, dn, an, 1'b0});
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_dout"}, Dout, model_dout);
        chk({tag, "_nstart"}, n_start, 1);
        chk({tag, "_nstop"}, n_stop, 1);
        chk({tag, "_nbytes"}, rec_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rec_b.size(); i++)
            chk({tag, "_byte"}, {rec_a[i], rec_b[i]}, exp_q[i]);
    endtask

    initial begin
        logic [6:0]  ra;
        logic        rrw, ran;
        logic [1:0]  rcm;
        logic [31:0] rdin, rrd;
        int          rnb, cyc;

        PRESET = 1'b1; con1 = '0; con2 = '0; Din = '0;
        model_dout = '0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_scl", scl_o, 1);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_ready", ready, 1);
        chk("rst_stat", stat, 0);
        chk("rst_dout", Dout, 0);
        PRESET = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;

        // Single-byte write
        set_target(1'b0, -1, '0);
        launch(7'h50, 1'b0, 2'd0, 32'h0000_00A5);
        check_xfer("w1", 7'h50, 1'b0, 2'd0, 32'h0000_00A5, '0, 1'b0, -1);
        chk("w1_addr_byte", rec_b[0], 8'hA0);

        // Three-byte read
        set_target(1'b0, -1, 32'h0056_3412);
        launch(7'h50, 1'b1, 2'd2, '0);
        check_xfer("r3", 7'h50, 1'b1, 2'd2, '0, 32'h0056_3412, 1'b0, -1);
        chk("r3_dout_abs", Dout, 32'h0056_3412);

        // Address NACK
        set_target(1'b1, -1, '0);
        launch(7'h2A, 1'b0, 2'd1, 32'h1234_5678);
        check_xfer("anack", 7'h2A, 1'b0, 2'd1, 32'h1234_5678, '0, 1'b1, -1);

        // Four-byte write, second byte NACKed
        set_target(1'b0, 1, '0);
        launch(7'h3C, 1'b0, 2'd3, 32'hDEAD_BEEF);
        check_xfer("dnack", 7'h3C, 1'b0, 2'd3, 32'hDEAD_BEEF, '0, 1'b0, 1);

        // Start toggled while busy, then held high after done
        set_target(1'b0, -1, '0);
        launch(7'h11, 1'b0, 2'd1, 32'h0000_C35A);
        repeat (100) @(posedge PCLK);
        #1 con1[0] = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 con1[0] = 1'b1;
        check_xfer("retrig", 7'h11, 1'b0, 2'd1, 32'h0000_C35A, '0, 1'b0, -1);
        repeat (60) @(posedge PCLK);
        #1;
        chk("retrig_hold_ready", ready, 1);
        chk("retrig_hold_nstart", n_start, 1);
        chk("retrig_hold_stat", stat, 8'h80);
        set_target(1'b0, -1, '0);
        launch(7'h22, 1'b0, 2'd0, 32'h0000_0077);
        check_xfer("fresh", 7'h22, 1'b0, 2'd0, 32'h0000_0077, '0, 1'b0, -1);

        // Reset during the second read byte
        set_target(1'b0, -1, 32'h00C3_9A5E);
        launch(7'h45, 1'b1, 2'd2, '0);
        cyc = 0;
        while (!(rec_b.size() == 2 && mon_bitc == 4) && cyc < 3000) begin
            @(posedge PCLK); #1;
            cyc++;
        end
        chk("midrst_reach", (rec_b.size() == 2 && mon_bitc == 4), 1);
        chk("midrst_pre_dout", Dout, 32'h0000_005E);
        PRESET = 1'b1;
        con1   = 8'h00;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        chk("midrst_scl", scl_o, 1);
        chk("midrst_sda_oe", sda_oe, 0);
        chk("midrst_stat", stat, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_dout", Dout, 0);
        model_dout = '0;
        repeat (10) @(posedge PCLK);
        #1;

        // Randomized transfers
        for (int k = 0; k < 8; k++) begin
            ra   = 7'($urandom);
            rrw  = 1'($urandom);
            rcm  = 2'($urandom);
            rdin = $urandom;
            rrd  = $urandom;
            ran  = ($urandom_range(0, 5) == 0);
            rnb  = (!rrw && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(rcm))) : -1;
            set_target(ran, rnb, rrd);
            launch(ra, rrw, rcm, rdin);
            check_xfer("rand", ra, rrw, rcm, rdin, rrd, ran, rnb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
